// File: rtl/mult_div_if.sv
// Operand/request and result/status bundle for the mult_div block.
// No latency of its own; plain wires grouped for port hookup.
// No backpressure; requests arriving while the block is busy are dropped.
interface mult_div_if;
    logic [31:0] a;
    logic [31:0] b;
    logic        mult_start;
    logic        div_start;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    modport master (
        output a, b, mult_start, div_start,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  a, b, mult_start, div_start,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div.sv
// Iterative signed 32x32 multiply (radix-2 Booth) and divide (restoring) into HI/LO.
// Latency: result and done at start edge + 33; divide-by-zero flagged at start edge + 1.
// No backpressure: starts are taken only in IDLE, anything else is ignored.
module mult_div (
    input  logic       clk,
    input  logic       reset,
    mult_div_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

    state_t      state;
    state_t      state_nxt;

    // acc is one bit wider than the operands so that subtracting a
    // multiplicand of 0x80000000 cannot wrap; in DIV it holds the remainder.
    logic [32:0] acc;
    logic [31:0] q;        // multiplier / dividend magnitude, becomes low product / quotient
    logic        q_1;      // Booth history bit
    logic [31:0] m;        // multiplicand / divisor magnitude
    logic [4:0]  cnt;
    logic        op_mult;
    logic        op_dz;
    logic        a_neg;
    logic        b_neg;

    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        busy_r;
    logic        done_r;
    logic        dz_r;

    logic [32:0] m_ext;
    logic [32:0] booth_sum;
    logic [32:0] rem_sh;
    logic [32:0] trial;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    assign bus.hi       = hi_r;
    assign bus.lo       = lo_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.div_zero = dz_r;

    assign a_mag  = bus.a[31] ? (32'd0 - bus.a) : bus.a;
    assign b_mag  = bus.b[31] ? (32'd0 - bus.b) : bus.b;
    assign m_ext  = {m[31], m};
    assign rem_sh = {acc[31:0], q[31]};
    assign trial  = rem_sh - {1'b0, m};

    // Booth add/subtract selection from the current {Q0, Q-1} pair
    always_comb begin
        booth_sum = acc;
        case ({q[0], q_1})
            2'b01:   booth_sum = acc + m_ext;
            2'b10:   booth_sum = acc - m_ext;
            default: booth_sum = acc;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: multiply wins a tie; a zero divisor jumps straight to FINISH
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.mult_start)     state_nxt = MULT;
                else if (bus.div_start) state_nxt = (bus.b == 32'd0) ? FINISH : DIV;
            end
            MULT:    if (cnt == 5'd31) state_nxt = FINISH;
            DIV:     if (cnt == 5'd31) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, one iteration per cycle, result/status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            q       <= '0;
            q_1     <= 1'b0;
            m       <= '0;
            cnt     <= '0;
            op_mult <= 1'b0;
            op_dz   <= 1'b0;
            a_neg   <= 1'b0;
            b_neg   <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dz_r    <= 1'b0;
        end else begin
            busy_r <= (state == MULT) || (state == DIV);
            done_r <= (state == FINISH);
            dz_r   <= (state == FINISH) && op_dz;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    acc <= '0;
                    q_1 <= 1'b0;
                    if (bus.mult_start) begin
                        op_mult <= 1'b1;
                        op_dz   <= 1'b0;
                        m       <= bus.a;
                        q       <= bus.b;
                    end else if (bus.div_start) begin
                        op_mult <= 1'b0;
                        op_dz   <= (bus.b == 32'd0);
                        a_neg   <= bus.a[31];
                        b_neg   <= bus.b[31];
                        m       <= b_mag;
                        q       <= a_mag;
                    end
                end
                MULT: begin
                    acc <= {booth_sum[32], booth_sum[32:1]};
                    q   <= {booth_sum[0], q[31:1]};
                    q_1 <= q[0];
                    cnt <= cnt + 5'd1;
                end
                DIV: begin
                    // Restore by keeping the shifted remainder when the trial goes negative
                    acc <= trial[32] ? rem_sh : trial;
                    q   <= {q[30:0], ~trial[32]};
                    cnt <= cnt + 5'd1;
                end
                FINISH: begin
                    if (op_mult) begin
                        hi_r <= acc[31:0];
                        lo_r <= q;
                    end else if (!op_dz) begin
                        lo_r <= (a_neg ^ b_neg) ? (32'd0 - q) : q;
                        hi_r <= a_neg ? (32'd0 - acc[31:0]) : acc[31:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
